// File: rtl/hs_unit_rr_arb_reg.sv
// Round-robin arbiter sharing one registered valid/ready output stage between
// NUM_REQ requesters; every beat is tagged with the index of its source.
module hs_unit_rr_arb_reg #(
    parameter int NUM_REQ = 4,
    parameter type DATA_TYPE = logic,
    parameter DATA_TYPE RESET_VALUE = DATA_TYPE'(1'b0),
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic [NUM_REQ-1:0] s_valid,
    input  DATA_TYPE           s_data [NUM_REQ],
    output logic [NUM_REQ-1:0] s_ready,
    output logic               m_valid,
    output DATA_TYPE           m_data,
    output logic [SRC_W-1:0]   m_src,
    input  logic               m_ready
);

    localparam logic [SRC_W:0]   NREQ = (SRC_W+1)'(NUM_REQ);
    localparam logic [SRC_W-1:0] LAST = SRC_W'(NUM_REQ - 1);

    logic [SRC_W-1:0]   ptr;
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   gidx;
    logic               found;
    logic [SRC_W:0]     sum;
    logic [SRC_W-1:0]   idx;
    logic               load;
    logic               xfer;

    assign load = !m_valid || m_ready;
    assign xfer = load && found;

    // Scan ptr, ptr+1, ... modulo NUM_REQ; the first valid requester wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (SRC_W+1)'(k);
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = sum[SRC_W-1:0];
            if (!found && s_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                gidx        = idx;
            end
        end
    end

    // Ready is forced low while reset is held so nothing is accepted then.
    assign s_ready = grant & {NUM_REQ{load && aresetn}};

    // Output stage: load a new beat, empty out, or hold under backpressure.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid <= 1'b0;
            m_data  <= RESET_VALUE;
            m_src   <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            m_valid <= 1'b1;
            m_data  <= s_data[gidx];
            m_src   <= gidx;
            ptr     <= (gidx == LAST) ? '0 : gidx + 1'b1;
        end else if (load) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hs_unit_rr_arb_reg.sv
// Directed bench for hs_unit_rr_arb_reg: a 4-requester and a 3-requester instance.
module tb_hs_unit_rr_arb_reg;

    logic       clk = 1'b0;
    logic       aresetn = 1'b0;

    logic [3:0] s_valid = '0;
    logic [7:0] s_data [4];
    logic [3:0] s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic [1:0] m_src;
    logic       m_ready = 1'b0;

    logic [2:0] s_valid3 = '0;
    logic [7:0] s_data3 [3];
    logic [2:0] s_ready3;
    logic       m_valid3;
    logic [7:0] m_data3;
    logic [1:0] m_src3;
    logic       m_ready3 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hs_unit_rr_arb_reg #(
        .NUM_REQ(4), .DATA_TYPE(logic [7:0]), .RESET_VALUE(8'hA5)
    ) dut4 (
        .clk(clk), .aresetn(aresetn),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_src(m_src), .m_ready(m_ready)
    );

    hs_unit_rr_arb_reg #(
        .NUM_REQ(3), .DATA_TYPE(logic [7:0]), .RESET_VALUE(8'h3C)
    ) dut3 (
        .clk(clk), .aresetn(aresetn),
        .s_valid(s_valid3), .s_data(s_data3), .s_ready(s_ready3),
        .m_valid(m_valid3), .m_data(m_data3), .m_src(m_src3), .m_ready(m_ready3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_valid  = '0;
        s_valid3 = '0;
        m_ready  = 1'b0;
        m_ready3 = 1'b0;
        aresetn  = 1'b0;
        step();
        step();
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_valid = 4'b1111;
        m_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        n_checks++;
        if (m_data !== 8'hA5) begin n_fail++; $display("FAIL reset_m_data got %h want a5", m_data); end
        n_checks++;
        if (m_src !== 2'd0) begin n_fail++; $display("FAIL reset_m_src got %0d want 0", m_src); end
        n_checks++;
        if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_s_ready got %b want 0000", s_ready); end
        aresetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_ready got %b want 0001", s_ready); end
        step();
        n_checks++;
        if (m_valid !== 1'b1 || m_src !== 2'd0 || m_data !== 8'hC0) begin
            n_fail++;
            $display("FAIL reset_first_beat got v=%b src=%0d d=%h want v=1 src=0 d=c0", m_valid, m_src, m_data);
        end
    endtask

    task automatic test_round_robin();
        int exp_src [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        s_valid = 4'b1111;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (m_valid !== 1'b1 || m_src !== 2'(exp_src[i]) || m_data !== (8'hC0 + 8'(exp_src[i]))) begin
                n_fail++;
                $display("FAIL rr4_beat%0d got v=%b src=%0d d=%h want v=1 src=%0d d=%h",
                         i, m_valid, m_src, m_data, exp_src[i], 8'hC0 + 8'(exp_src[i]));
            end
        end
    endtask

    task automatic test_sparse();
        int exp_src [4] = '{1, 3, 1, 3};
        do_reset();
        s_valid = 4'b1010;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (s_ready !== (4'b0001 << exp_src[i])) begin
                n_fail++;
                $display("FAIL sparse_ready%0d got %b want %b", i, s_ready, 4'b0001 << exp_src[i]);
            end
            step();
            n_checks++;
            if (m_valid !== 1'b1 || m_src !== 2'(exp_src[i])) begin
                n_fail++;
                $display("FAIL sparse_src%0d got v=%b src=%0d want v=1 src=%0d", i, m_valid, m_src, exp_src[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        s_valid = 4'b0100;
        m_ready = 1'b0;
        step();
        n_checks++;
        if (m_valid !== 1'b1 || m_src !== 2'd2 || m_data !== 8'hC2) begin
            n_fail++;
            $display("FAIL bp_load got v=%b src=%0d d=%h want v=1 src=2 d=c2", m_valid, m_src, m_data);
        end
        s_valid = 4'b1111;
        s_data[2] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d got %b want 0000", i, s_ready); end
            step();
            n_checks++;
            if (m_valid !== 1'b1 || m_src !== 2'd2 || m_data !== 8'hC2) begin
                n_fail++;
                $display("FAIL bp_hold%0d got v=%b src=%0d d=%h want v=1 src=2 d=c2", i, m_valid, m_src, m_data);
            end
        end
        s_data[2] = 8'hC2;
        m_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_ready got %b want 1000", s_ready); end
        step();
        n_checks++;
        if (m_src !== 2'd3 || m_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL bp_release_src got src=%0d d=%h want src=3 d=c3", m_src, m_data);
        end
    endtask

    task automatic test_drain();
        do_reset();
        s_valid = 4'b0010;
        m_ready = 1'b1;
        step();
        s_valid = 4'b0000;
        n_checks++;
        if (m_valid !== 1'b1 || m_src !== 2'd1 || m_data !== 8'hC1) begin
            n_fail++;
            $display("FAIL drain_beat got v=%b src=%0d d=%h want v=1 src=1 d=c1", m_valid, m_src, m_data);
        end
        step();
        n_checks++;
        if (m_valid !== 1'b0 || m_src !== 2'd1 || m_data !== 8'hC1) begin
            n_fail++;
            $display("FAIL drain_empty got v=%b src=%0d d=%h want v=0 src=1 d=c1", m_valid, m_src, m_data);
        end
        s_valid = 4'b1111;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 4'b0100) begin n_fail++; $display("FAIL drain_ptr_ready got %b want 0100", s_ready); end
        step();
        n_checks++;
        if (m_src !== 2'd2) begin n_fail++; $display("FAIL drain_ptr_src got %0d want 2", m_src); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        s_valid = 4'b1111;
        m_ready = 1'b1;
        step();
        step();
        m_ready = 1'b0;
        step();
        n_checks++;
        if (m_valid !== 1'b1 || m_src !== 2'd1) begin
            n_fail++;
            $display("FAIL midrst_pending got v=%b src=%0d want v=1 src=1", m_valid, m_src);
        end
        #2;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || m_src !== 2'd0 || m_data !== 8'hA5 || s_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_async got v=%b src=%0d d=%h rdy=%b want v=0 src=0 d=a5 rdy=0000",
                     m_valid, m_src, m_data, s_ready);
        end
        step();
        aresetn = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_restart_ready got %b want 0001", s_ready); end
        step();
        n_checks++;
        if (m_valid !== 1'b1 || m_src !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_restart_src got v=%b src=%0d want v=1 src=0", m_valid, m_src);
        end
    endtask

    task automatic test_round_robin_3();
        int exp_src [4] = '{0, 1, 2, 0};
        do_reset();
        s_valid3 = 3'b111;
        m_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (s_ready3 !== (3'b001 << exp_src[i])) begin
                n_fail++;
                $display("FAIL rr3_ready%0d got %b want %b", i, s_ready3, 3'b001 << exp_src[i]);
            end
            step();
            n_checks++;
            if (m_valid3 !== 1'b1 || m_src3 !== 2'(exp_src[i]) || m_data3 !== (8'h70 + 8'(exp_src[i]))) begin
                n_fail++;
                $display("FAIL rr3_beat%0d got v=%b src=%0d d=%h want v=1 src=%0d d=%h",
                         i, m_valid3, m_src3, m_data3, exp_src[i], 8'h70 + 8'(exp_src[i]));
            end
        end
        s_valid3 = '0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) s_data[i] = 8'hC0 + 8'(i);
        for (int i = 0; i < 3; i++) s_data3[i] = 8'h70 + 8'(i);
        #1;
        test_reset();
        test_round_robin();
        test_sparse();
        test_backpressure();
        test_drain();
        test_reset_mid_run();
        test_round_robin_3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
